// File: rtl/divider.sv
// Iterative radix-2 non-restoring divider for RISC-V DIV/DIVU/REM/REMU with ready/flush handshake.
// Define DIV_EARLY_OUT_EN to finish early when |dividend| < |divisor|; results are identical either way.
module divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [1:0]      mode,
    input  logic            flush,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN:0]   p_q;
    logic [XLEN-1:0] q_q;
    logic [XLEN-1:0] d_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic            is_rem_q;

    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic            early;
    logic [XLEN:0]   p_sh;
    logic [XLEN:0]   p_d;
    logic [XLEN:0]   p_fix;
    logic [XLEN-1:0] quo_res;
    logic [XLEN-1:0] rem_res;

    assign ready_o = (state_q == IDLE);

    always_comb begin
        is_signed = ~mode[0];
        a_neg     = is_signed & op1[XLEN-1];
        b_neg     = is_signed & op2[XLEN-1];
        a_mag     = a_neg ? (~op1 + 1'b1) : op1;
        b_mag     = b_neg ? (~op2 + 1'b1) : op2;
        div_zero  = (op2 == '0);
        overflow  = is_signed && (op1 == MIN_NEG) && (op2 == '1);
`ifdef DIV_EARLY_OUT_EN
        early     = !div_zero && (a_mag < b_mag);
`else
        early     = 1'b0;
`endif
    end

    // The decision uses the sign of the unshifted remainder: the shift may overflow
    // XLEN+1 bits, but the add/sub brings the value back into range modulo 2^(XLEN+1).
    always_comb begin
        p_sh    = {p_q[XLEN-1:0], q_q[XLEN-1]};
        p_d     = p_q[XLEN] ? (p_sh + {1'b0, d_q}) : (p_sh - {1'b0, d_q});
        p_fix   = p_q[XLEN] ? (p_q + {1'b0, d_q}) : p_q;
        quo_res = q_neg_q ? (~q_q + 1'b1) : q_q;
        rem_res = r_neg_q ? (~p_fix[XLEN-1:0] + 1'b1) : p_fix[XLEN-1:0];
    end

    // NOTE: all state updates here are non-blocking so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_rem_q <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            valid_o <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (valid_i) begin
                            is_rem_q <= mode[1];
                            cnt_q    <= '0;
                            d_q      <= b_mag;
                            if (div_zero) begin
                                // Raw results with cleared signs pass through FIX unchanged.
                                q_q     <= '1;
                                p_q     <= {1'b0, op1};
                                q_neg_q <= 1'b0;
                                r_neg_q <= 1'b0;
                                state_q <= FIX;
                            end else if (overflow) begin
                                q_q     <= MIN_NEG;
                                p_q     <= '0;
                                q_neg_q <= 1'b0;
                                r_neg_q <= 1'b0;
                                state_q <= FIX;
                            end else if (early) begin
                                q_q     <= '0;
                                p_q     <= {1'b0, a_mag};
                                q_neg_q <= a_neg ^ b_neg;
                                r_neg_q <= a_neg;
                                state_q <= FIX;
                            end else begin
                                q_q     <= a_mag;
                                p_q     <= '0;
                                q_neg_q <= a_neg ^ b_neg;
                                r_neg_q <= a_neg;
                                state_q <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        p_q   <= p_d;
                        q_q   <= {q_q[XLEN-2:0], ~p_d[XLEN]};
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(XLEN - 1)) begin
                            state_q <= FIX;
                        end
                    end
                    FIX: begin
                        result_o <= is_rem_q ? rem_res : quo_res;
                        valid_o  <= 1'b1;
                        state_q  <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider: results, latency, back-to-back issue, flush and reset.
module tb_divider;

    localparam int XLEN = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_i;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [1:0]      mode;
    logic            flush;
    logic            ready_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    divider #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .op1      (op1),
        .op2      (op2),
        .mode     (mode),
        .flush    (flush),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single edge (E0); returns #1 after E0.
    task automatic start_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mode    = m;
        op1     = a;
        op2     = b;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    // Counts edges after E0 until valid_o is seen; elapsed = edges already consumed by the caller.
    task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_lat, input int elapsed);
        int lat;
        bit seen;
        lat  = elapsed;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            seen = valid_o;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, result_o, exp);
        check({tag, "_rdy"}, {31'b0, ready_o}, 32'd1);
    endtask

    task automatic no_valid(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) pulses++;
        end
        check(tag, pulses, 0);
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        flush   = 1'b0;
        mode    = 2'b00;
        op1     = '0;
        op2     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready",  {31'b0, ready_o}, 32'd1);
        check("reset_valid",  {31'b0, valid_o}, 32'd0);
        check("reset_result", result_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Signed quotient/remainder, second op issued in the first op's valid cycle.
        start_op(2'b00, 32'd20, 32'hFFFF_FFFD);
        wait_done("div_20_m3", 32'hFFFF_FFFA, 33, 0);
        start_op(2'b10, 32'd20, 32'hFFFF_FFFD);
        wait_done("rem_20_m3", 32'h0000_0002, 33, 0);
        start_op(2'b00, 32'hFFFF_FFEC, 32'd3);
        wait_done("div_m20_3", 32'hFFFF_FFFA, 33, 0);
        start_op(2'b10, 32'hFFFF_FFEC, 32'd3);
        wait_done("rem_m20_3", 32'hFFFF_FFFE, 33, 0);

        // Unsigned, back-to-back.
        start_op(2'b01, 32'hFFFF_FFFF, 32'd2);
        wait_done("divu_max_2", 32'h7FFF_FFFF, 33, 0);
        start_op(2'b11, 32'hFFFF_FFFF, 32'd2);
        wait_done("remu_max_2", 32'h0000_0001, 33, 0);

        // Divide by zero and signed overflow take the short path.
        start_op(2'b00, 32'd7, 32'd0);
        wait_done("div_by0", 32'hFFFF_FFFF, 1, 0);
        start_op(2'b11, 32'd7, 32'd0);
        wait_done("remu_by0", 32'h0000_0007, 1, 0);
        start_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 32'h8000_0000, 1, 0);
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("rem_ovf", 32'h0000_0000, 1, 0);

        // valid_o is a single-cycle strobe; result_o holds.
        @(posedge clk);
        #1;
        check("strobe_width", {31'b0, valid_o}, 32'd0);
        check("result_hold",  result_o, 32'h0);

        // Dividend smaller than divisor.
        start_op(2'b01, 32'd5, 32'd7);
        wait_done("divu_5_7", 32'h0, EARLY_LAT, 0);
        start_op(2'b11, 32'd5, 32'd7);
        wait_done("remu_5_7", 32'h5, EARLY_LAT, 0);

        // Flush while cnt==10: no result, ready next cycle, result_o untouched.
        start_op(2'b01, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_ready", {31'b0, ready_o}, 32'd1);
        check("flush_valid", {31'b0, valid_o}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        no_valid("flush_no_valid", 40);
        check("flush_keeps_result", result_o, 32'h5);
        start_op(2'b01, 32'd100, 32'd7);
        wait_done("divu_100_7", 32'd14, 33, 0);

        // flush together with valid_i in IDLE: not accepted.
        @(negedge clk);
        mode    = 2'b01;
        op1     = 32'd9;
        op2     = 32'd3;
        valid_i = 1'b1;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush   = 1'b0;
        check("flush_accept_ready", {31'b0, ready_o}, 32'd1);
        no_valid("flush_accept_no_valid", 40);

        // Requests and mode changes during CALC are ignored.
        start_op(2'b00, 32'd20, 32'hFFFF_FFFD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mode    = 2'b11;
            op1     = 32'd100;
            op2     = 32'd7;
            valid_i = 1'b1;
            @(posedge clk);
            #1;
            check("busy_not_ready", {31'b0, ready_o}, 32'd0);
        end
        valid_i = 1'b0;
        wait_done("busy_ignored", 32'hFFFF_FFFA, 33, 5);

        // Reset at cnt==5 aborts with reset values and no stale strobe.
        start_op(2'b01, 32'hFFFF_FFFF, 32'd2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid",  {31'b0, valid_o}, 32'd0);
        check("midrst_result", result_o, 32'h0);
        check("midrst_ready",  {31'b0, ready_o}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        no_valid("midrst_no_valid", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Iterative radix-2 non-restoring integer divider for the RISC-V M-extension: DIV, DIVU, REM, REMU.
- Companion to the pipelined multiplier in the execute stage. It takes the same operand, mode and valid interface and is fed by the same reservation-station issue logic.
- Not pipelined, so it adds a ready/busy handshake and a flush input for branch misprediction.

Parameters:
- XLEN, 32, operand and result width. Iteration count equals XLEN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  operation request; accepted only when ready_o=1
- op1  in  XLEN  dividend (rs1)
- op2  in  XLEN  divisor (rs2)
- mode  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- flush  in  1  kill in-flight operation
- ready_o  out  1  divider idle, can accept this cycle
- valid_o  out  1  one-cycle result strobe
- result_o  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-high, sampled on the clk rising edge.
  - Reset values: state=IDLE, valid_o=0, result_o=0. ready_o=1 in the first cycle after reset.
- ready_o is combinational: (state==IDLE).
  - An operation is accepted on an edge where valid_i=1, ready_o=1 and flush=0. Call that edge E0.
- Operand capture at E0:
  - Signed modes (DIV, REM) convert operands to magnitudes and latch sign flags.
  - Quotient sign = sign(op1) XOR sign(op2). Remainder sign = sign(op1).
  - Unsigned modes clear both sign flags.
- States:
  - IDLE: wait for acceptance. On acceptance go to CALC with cnt=0, unless a special case applies, in which case go to FIX.
  - CALC: one non-restoring iteration per edge on an XLEN+1-bit partial remainder. cnt increments each edge. On the edge where cnt==XLEN-1, go to FIX. CALC therefore lasts XLEN edges, E1..E32 for XLEN=32.
  - FIX: apply the final remainder correction (add back the divisor if the partial remainder is negative), then sign restoration. On the next edge drive result_o and valid_o=1, and go to IDLE.
- Normal latency: valid_o is high in the cycle after E33, i.e. 33 edges after acceptance.
  - ready_o is high in that same cycle, so back-to-back issue is legal.
- Special cases are detected at E0, skip CALC, and produce valid_o in the cycle after E1:
  - Divisor = 0:
    - DIV/DIVU give quotient all-ones.
    - REM/REMU give remainder = op1.
  - Signed overflow (DIV/REM, op1=0x80000000, op2=0xFFFFFFFF):
    - Quotient = 0x80000000.
    - Remainder = 0.
- valid_o is exactly one cycle wide and deasserts on the following edge.
  - result_o holds its last value until the next completion.
- valid_i while ready_o=0 is ignored. No queuing; the upstream issue logic must hold or retry.
- Flush:
  - flush=1 in any state returns to IDLE on that edge and suppresses the pending valid_o.
  - This includes FIX: no valid_o is produced.
  - flush=1 together with valid_i in IDLE means the request is not accepted.
  - flush does not alter result_o.
- rst mid-operation aborts immediately with the reset values above. No stale valid_o after reset.
- Mode is latched at E0. Changes on the mode input after E0 have no effect on the in-flight operation.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - At E0, if the unsigned magnitude of the dividend < the magnitude of the divisor (divisor nonzero), skip CALC and go to FIX with quotient=0 and remainder=dividend magnitude.
  - Sign restoration is applied as normal.
  - valid_o is high in the cycle after E1, the same as the special cases.
- Undefined: every non-special operation takes the full 33-edge latency.
- Results are bit-identical either way; only latency differs.

Test Plan:
- DIV op1=20, op2=0xFFFFFFFD (-3) -> result_o=0xFFFFFFFA (-6), valid_o high 33 edges after E0. Same operands with REM -> 0x00000002.
- DIVU op1=0xFFFFFFFF, op2=2 -> 0x7FFFFFFF. REMU same operands -> 0x00000001. Issue a new op in the valid_o cycle; the second result is correct.
- Divide by zero: DIV 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 0x00000007. Both produce valid_o in the cycle after E1.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000. Both on the short latency.
- Assert flush at CALC cnt=10 -> no valid_o ever for that op, ready_o=1 next cycle. A following DIVU 100/7 -> 14 at normal latency.
- Drive valid_i with other operands during CALC -> ignored, original result delivered. Assert rst at cnt=5 -> valid_o=0, result_o=0, ready_o=1 after the reset edge.
